// File: rtl/alu_pkg.sv
// Shared encodings for the APCPU execute unit: opcodes, bus/PC/SP/register commands.
// No logic; constants and status-register bit positions only.
// FSM state codes kept as plain localparams for compatibility with older tooling.
package alu_pkg;

    // Opcodes (decimal values as issued by the decoder)
    localparam logic [7:0] OP_NOP   = 8'd0;
    localparam logic [7:0] OP_ADD   = 8'd1;
    localparam logic [7:0] OP_SUB   = 8'd2;
    localparam logic [7:0] OP_AND   = 8'd3;
    localparam logic [7:0] OP_OR    = 8'd4;
    localparam logic [7:0] OP_XOR   = 8'd5;
    localparam logic [7:0] OP_NOT   = 8'd6;
    localparam logic [7:0] OP_SHL   = 8'd7;
    localparam logic [7:0] OP_SHR   = 8'd8;
    localparam logic [7:0] OP_CMP   = 8'd9;
    localparam logic [7:0] OP_MOVI  = 8'd16;
    localparam logic [7:0] OP_LOAD  = 8'd25;
    localparam logic [7:0] OP_STORE = 8'd26;
    localparam logic [7:0] OP_PUSH  = 8'd32;
    localparam logic [7:0] OP_POP   = 8'd33;
    localparam logic [7:0] OP_SETSP = 8'd34;
    localparam logic [7:0] OP_JMP   = 8'd48;
    localparam logic [7:0] OP_JZ    = 8'd49;

    // MemIO bus command
    localparam logic [1:0] MEM_IDLE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    // MenagePC command
    localparam logic [2:0] PC_HOLD  = 3'b000;
    localparam logic [2:0] PC_ADV   = 3'b001;
    localparam logic [2:0] PC_LOAD  = 3'b010;

    // InDecSP command
    localparam logic [1:0] SP_NONE  = 2'b00;
    localparam logic [1:0] SP_INC   = 2'b01;
    localparam logic [1:0] SP_DEC   = 2'b10;
    localparam logic [1:0] SP_LOAD  = 2'b11;

    // SetAP register-write target
    localparam logic [2:0] AP_NONE  = 3'b000;
    localparam logic [2:0] AP_A     = 3'b001;
    localparam logic [2:0] AP_B     = 3'b010;

    // Status register bit positions; bits 7:4 are never touched here
    localparam int SR_Z = 0;
    localparam int SR_C = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 3;

    // Controller FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/alu_core.sv
// Combinational result and flag generation for register ops (opcodes 1-9, 16).
// Latency: zero (pure logic); the caller registers the outputs.
// No handshake; any other opcode yields a zero result, unchanged SR and no write.
module alu_core
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int IMMW = 24
) (
    input  logic [7:0]      op_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    input  logic [IMMW-1:0] imm_i,
    input  logic [7:0]      sr_i,
    output logic [DW-1:0]   res_o,
    output logic [7:0]      sr_o,
    output logic            wr_a_o
);

    logic [DW:0] sum;
    logic [DW:0] diff;
    logic [DW:0] shl_ext;
    logic [DW:0] shr_ext;

    // Carry/borrow come from the extra top bit; shifts keep the bit shifted out
    // in an extension bit, which is naturally 0 for a shift amount of 0.
    assign sum     = {1'b0, a_i} + {1'b0, b_i};
    assign diff    = {1'b0, a_i} - {1'b0, b_i};
    assign shl_ext = {1'b0, a_i} << b_i[4:0];
    assign shr_ext = {a_i, 1'b0} >> b_i[4:0];

    // Select result, write enable and the new Z/C/N/V per opcode
    always_comb begin
        logic upd;
        logic c;
        logic v;
        res_o  = '0;
        sr_o   = sr_i;
        wr_a_o = 1'b0;
        upd    = 1'b0;
        c      = 1'b0;
        v      = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o  = sum[DW-1:0];
                c      = sum[DW];
                v      = (a_i[DW-1] == b_i[DW-1]) && (sum[DW-1] != a_i[DW-1]);
                upd    = 1'b1;
                wr_a_o = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                res_o  = diff[DW-1:0];
                c      = diff[DW];
                v      = (a_i[DW-1] != b_i[DW-1]) && (diff[DW-1] != a_i[DW-1]);
                upd    = 1'b1;
                wr_a_o = (op_i == OP_SUB);
            end
            OP_AND: begin res_o = a_i & b_i; upd = 1'b1; wr_a_o = 1'b1; end
            OP_OR:  begin res_o = a_i | b_i; upd = 1'b1; wr_a_o = 1'b1; end
            OP_XOR: begin res_o = a_i ^ b_i; upd = 1'b1; wr_a_o = 1'b1; end
            OP_NOT: begin res_o = ~a_i;      upd = 1'b1; wr_a_o = 1'b1; end
            OP_SHL: begin
                res_o  = shl_ext[DW-1:0];
                c      = shl_ext[DW];
                v      = sr_i[SR_V];
                upd    = 1'b1;
                wr_a_o = 1'b1;
            end
            OP_SHR: begin
                res_o  = shr_ext[DW:1];
                c      = shr_ext[0];
                v      = sr_i[SR_V];
                upd    = 1'b1;
                wr_a_o = 1'b1;
            end
            OP_MOVI: begin
                res_o  = {{(DW-IMMW){1'b0}}, imm_i};
                wr_a_o = 1'b1;
            end
            default: ;
        endcase
        if (upd) begin
            sr_o[SR_Z] = (res_o == '0);
            sr_o[SR_N] = res_o[DW-1];
            sr_o[SR_C] = c;
            sr_o[SR_V] = v;
        end
    end

endmodule

// File: rtl/alu.sv
// APCPU execute unit: IDLE -> EXEC -> (MEM) -> DONE controller with registered outputs.
// Latency: register ops 2 cycles from issue to MenagePC; memory ops 2 + wait cycles.
// Backpressure: MEM holds the bus command until ValidMemData, with no timeout.
module alu
    import alu_pkg::*;
#(
    parameter int DW   = 32,
    parameter int IMMW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   A,
    input  logic [DW-1:0]   B,
    input  logic [7:0]      ALU_Sel,
    input  logic            ValidMemData,
    input  logic [IMMW-1:0] DecoderData,
    input  logic [7:0]      StatusRegisterVelues,
    input  logic [DW-1:0]   SPAddr,
    inout  wire  [DW-1:0]   DataIO,
    output logic [DW-1:0]   SetSP,
    output logic [1:0]      InDecSP,
    output logic [1:0]      MemIO,
    output logic [DW-1:0]   ALUAddr,
    output logic [2:0]      MenagePC,
    output logic [DW-1:0]   PCSet,
    output logic [7:0]      SetSR,
    output logic [2:0]      SetAP
);

    logic [1:0]      state_q,  state_d;
    logic [7:0]      op_q,     op_d;
    logic [DW-1:0]   a_q,      a_d;
    logic [DW-1:0]   b_q,      b_d;
    logic [IMMW-1:0] imm_q,    imm_d;
    logic [7:0]      sr_q,     sr_d;
    logic [DW-1:0]   sp_q,     sp_d;
    logic [DW-1:0]   set_sp_q, set_sp_d;
    logic [1:0]      indec_q,  indec_d;
    logic [1:0]      mem_io_q, mem_io_d;
    logic [DW-1:0]   addr_q,   addr_d;
    logic [2:0]      mpc_q,    mpc_d;
    logic [DW-1:0]   pc_set_q, pc_set_d;
    logic [7:0]      set_sr_q, set_sr_d;
    logic [2:0]      set_ap_q, set_ap_d;
    logic [DW-1:0]   dio_q,    dio_d;
    logic            dio_oe_q, dio_oe_d;

    logic [DW-1:0]   core_res;
    logic [7:0]      core_sr;
    logic            core_wr_a;

    alu_core #(.DW(DW), .IMMW(IMMW)) u_core (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .imm_i  (imm_q),
        .sr_i   (sr_q),
        .res_o  (core_res),
        .sr_o   (core_sr),
        .wr_a_o (core_wr_a)
    );

    assign DataIO   = dio_oe_q ? dio_q : {DW{1'bz}};
    assign SetSP    = set_sp_q;
    assign InDecSP  = indec_q;
    assign MemIO    = mem_io_q;
    assign ALUAddr  = addr_q;
    assign MenagePC = mpc_q;
    assign PCSet    = pc_set_q;
    assign SetSR    = set_sr_q;
    assign SetAP    = set_ap_q;

    // Next-state logic; strobes default to 0 so DONE lasts exactly one cycle,
    // while address/PC/SP load values hold until the next op overwrites them.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        sr_d     = sr_q;
        sp_d     = sp_q;
        set_sp_d = set_sp_q;
        indec_d  = SP_NONE;
        mem_io_d = mem_io_q;
        addr_d   = addr_q;
        mpc_d    = PC_HOLD;
        pc_set_d = pc_set_q;
        set_sr_d = '0;
        set_ap_d = AP_NONE;
        dio_d    = dio_q;
        dio_oe_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ALU_Sel != OP_NOP) begin
                    op_d    = ALU_Sel;
                    a_d     = A;
                    b_d     = B;
                    imm_d   = DecoderData;
                    sr_d    = StatusRegisterVelues;
                    sp_d    = SPAddr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        addr_d   = a_q;
                        mem_io_d = MEM_RD;
                        state_d  = ST_MEM;
                    end
                    OP_STORE: begin
                        addr_d   = a_q;
                        mem_io_d = MEM_WR;
                        dio_d    = b_q;
                        dio_oe_d = 1'b1;
                        state_d  = ST_MEM;
                    end
                    OP_PUSH: begin
                        addr_d   = sp_q;
                        mem_io_d = MEM_WR;
                        dio_d    = a_q;
                        dio_oe_d = 1'b1;
                        state_d  = ST_MEM;
                    end
                    OP_POP: begin
                        addr_d   = sp_q + 1'b1;
                        mem_io_d = MEM_RD;
                        state_d  = ST_MEM;
                    end
                    default: begin
                        // Register, jump and SP ops all finish here
                        state_d  = ST_DONE;
                        mpc_d    = PC_ADV;
                        set_sr_d = core_sr;
                        if (core_wr_a) begin
                            set_ap_d = AP_A;
                            dio_d    = core_res;
                            dio_oe_d = 1'b1;
                        end
                        if (op_q == OP_SETSP) begin
                            set_sp_d = a_q;
                            indec_d  = SP_LOAD;
                        end
                        if ((op_q == OP_JMP) || (op_q == OP_JZ && sr_q[SR_Z])) begin
                            pc_set_d = {{(DW-IMMW){1'b0}}, imm_q};
                            mpc_d    = PC_LOAD;
                        end
                    end
                endcase
            end
            ST_MEM: begin
                if (ValidMemData) begin
                    state_d  = ST_DONE;
                    mem_io_d = MEM_IDLE;
                    mpc_d    = PC_ADV;
                    set_sr_d = sr_q;
                    if (mem_io_q == MEM_RD) begin
                        dio_d    = DataIO;
                        dio_oe_d = 1'b1;
                        set_ap_d = AP_A;
                    end
                    if (op_q == OP_PUSH) indec_d = SP_DEC;
                    if (op_q == OP_POP)  indec_d = SP_INC;
                end else begin
                    dio_oe_d = dio_oe_q;
                end
            end
            default: begin
                // DONE: strobes and bus drive fall back to their defaults
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            sr_q     <= '0;
            sp_q     <= '0;
            set_sp_q <= '0;
            indec_q  <= SP_NONE;
            mem_io_q <= MEM_IDLE;
            addr_q   <= '0;
            mpc_q    <= PC_HOLD;
            pc_set_q <= '0;
            set_sr_q <= '0;
            set_ap_q <= AP_NONE;
            dio_q    <= '0;
            dio_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            imm_q    <= imm_d;
            sr_q     <= sr_d;
            sp_q     <= sp_d;
            set_sp_q <= set_sp_d;
            indec_q  <= indec_d;
            mem_io_q <= mem_io_d;
            addr_q   <= addr_d;
            mpc_q    <= mpc_d;
            pc_set_q <= pc_set_d;
            set_sr_q <= set_sr_d;
            set_ap_q <= set_ap_d;
            dio_q    <= dio_d;
            dio_oe_q <= dio_oe_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the APCPU execute unit with a behavioural reference model.
// Directed cases from the feature list, then randomized opcodes and operands.
// Memory is modelled in the bench with a configurable ValidMemData delay.
module tb_alu;

    localparam logic [31:0] PROBE = 32'h5A5A_A5A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0, B = '0, SPAddr = '0;
    logic [7:0]  ALU_Sel = '0, StatusRegisterVelues = '0;
    logic        ValidMemData = 1'b0;
    logic [23:0] DecoderData = '0;
    wire  [31:0] DataIO;
    logic [31:0] SetSP, ALUAddr, PCSet;
    logic [1:0]  InDecSP, MemIO;
    logic [2:0]  MenagePC, SetAP;
    logic [7:0]  SetSR;

    logic        mem_oe = 1'b0;
    logic [31:0] mem_dat = '0;
    assign DataIO = mem_oe ? mem_dat : 32'bz;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_sp = '0;

    alu dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALU_Sel(ALU_Sel),
        .ValidMemData(ValidMemData), .DecoderData(DecoderData),
        .StatusRegisterVelues(StatusRegisterVelues), .SPAddr(SPAddr),
        .DataIO(DataIO), .SetSP(SetSP), .InDecSP(InDecSP), .MemIO(MemIO),
        .ALUAddr(ALUAddr), .MenagePC(MenagePC), .PCSet(PCSet), .SetSR(SetSR),
        .SetAP(SetAP)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [7:0]  sr;
        logic [2:0]  ap;
        logic [2:0]  pc;
        logic [1:0]  indec;
        logic [1:0]  mem;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] pcset;
        logic [31:0] setsp;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drive a known value onto the bus; it reads back intact only if the DUT is not driving
    task automatic check_bus_free(input string tag);
        mem_dat = PROBE;
        mem_oe  = 1'b1;
        #1;
        check(tag, DataIO, PROBE);
        mem_oe  = 1'b0;
        #1;
    endtask

    function automatic logic [7:0] mk_sr(input logic [7:0] sr, input bit z, c, n, v);
        return {sr[7:4], v, n, c, z};
    endfunction

    // Reference model: expected DONE-cycle outputs from the opcode rules
    function automatic exp_t model(input logic [7:0] op, input logic [31:0] a, b,
                                   input logic [23:0] imm, input logic [7:0] sr,
                                   input logic [31:0] sp, input logic [31:0] rdata);
        exp_t e;
        longint u, s;
        longint lim;
        int n;
        logic [31:0] r, t;
        bit c;
        lim = 64'sh8000_0000;
        e.res = '0; e.sr = sr; e.ap = 3'd0; e.pc = 3'd1; e.indec = 2'd0;
        e.mem = 2'd0; e.addr = '0; e.wdat = '0; e.pcset = exp_pc; e.setsp = exp_sp;
        n = int'(b[4:0]);
        case (op)
            8'd1: begin
                u = longint'(a) + longint'(b);
                s = longint'($signed(a)) + longint'($signed(b));
                r = a + b;
                e.res = r; e.ap = 3'd1;
                e.sr = mk_sr(sr, r == 0, u > 64'h0_FFFF_FFFF, r[31], (s >= lim) || (s < -lim));
            end
            8'd2, 8'd9: begin
                s = longint'($signed(a)) - longint'($signed(b));
                r = a - b;
                e.res = r; e.ap = (op == 8'd2) ? 3'd1 : 3'd0;
                e.sr = mk_sr(sr, r == 0, a < b, r[31], (s >= lim) || (s < -lim));
            end
            8'd3, 8'd4, 8'd5, 8'd6: begin
                r = (op == 8'd3) ? (a & b) : (op == 8'd4) ? (a | b) : (op == 8'd5) ? (a ^ b) : ~a;
                e.res = r; e.ap = 3'd1;
                e.sr = mk_sr(sr, r == 0, 1'b0, r[31], 1'b0);
            end
            8'd7: begin
                r = a << n;
                t = (n == 0) ? 32'd0 : (a >> (32 - n));
                c = t[0];
                e.res = r; e.ap = 3'd1;
                e.sr = mk_sr(sr, r == 0, c, r[31], sr[3]);
            end
            8'd8: begin
                r = a >> n;
                t = (n == 0) ? 32'd0 : (a >> (n - 1));
                c = t[0];
                e.res = r; e.ap = 3'd1;
                e.sr = mk_sr(sr, r == 0, c, r[31], sr[3]);
            end
            8'd16: begin e.res = {8'd0, imm}; e.ap = 3'd1; end
            8'd25: begin e.mem = 2'd1; e.addr = a; e.res = rdata; e.ap = 3'd1; end
            8'd26: begin e.mem = 2'd2; e.addr = a; e.wdat = b; end
            8'd32: begin e.mem = 2'd2; e.addr = sp; e.wdat = a; e.indec = 2'd2; end
            8'd33: begin e.mem = 2'd1; e.addr = sp + 1; e.res = rdata; e.ap = 3'd1; e.indec = 2'd1; end
            8'd34: begin e.indec = 2'd3; e.setsp = a; end
            8'd48: begin e.pc = 3'd2; e.pcset = {8'd0, imm}; end
            8'd49: if (sr[0]) begin e.pc = 3'd2; e.pcset = {8'd0, imm}; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a, b,
                          input logic [23:0] imm, input logic [7:0] sr, input logic [31:0] sp,
                          input logic [31:0] rdata, input int dly);
        exp_t e;
        int cyc, mcyc;
        bit done;
        e = model(op, a, b, imm, sr, sp, rdata);
        @(negedge clk);
        ALU_Sel = op; A = a; B = b; DecoderData = imm;
        StatusRegisterVelues = sr; SPAddr = sp;
        @(posedge clk);
        #1 ALU_Sel = 8'd0;
        cyc = 0; mcyc = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (MenagePC != 3'b000) begin
                done = 1'b1;
            end else if (MemIO != 2'b00) begin
                mcyc++;
                check({tag, ":MemIO"}, {30'd0, MemIO}, {30'd0, e.mem});
                check({tag, ":ALUAddr"}, ALUAddr, e.addr);
                if (e.mem == 2'd2) check({tag, ":wr_data"}, DataIO, e.wdat);
                if (mcyc >= dly) begin
                    ValidMemData = 1'b1;
                    if (e.mem == 2'd1) begin mem_dat = rdata; mem_oe = 1'b1; end
                    @(posedge clk);
                    #1;
                    ValidMemData = 1'b0;
                    mem_oe = 1'b0;
                end
            end
        end
        check({tag, ":done_seen"}, {31'd0, done}, 32'd1);
        if (done) begin
            check({tag, ":latency"}, cyc, (e.mem != 2'd0) ? dly + 2 : 2);
            check({tag, ":MenagePC"}, {29'd0, MenagePC}, {29'd0, e.pc});
            check({tag, ":SetAP"}, {29'd0, SetAP}, {29'd0, e.ap});
            check({tag, ":SetSR"}, {24'd0, SetSR}, {24'd0, e.sr});
            check({tag, ":InDecSP"}, {30'd0, InDecSP}, {30'd0, e.indec});
            check({tag, ":MemIO_done"}, {30'd0, MemIO}, 32'd0);
            check({tag, ":PCSet"}, PCSet, e.pcset);
            check({tag, ":SetSP"}, SetSP, e.setsp);
            if (e.ap != 3'd0) check({tag, ":DataIO"}, DataIO, e.res);
            else check_bus_free({tag, ":bus_free_done"});
            exp_pc = e.pcset;
            exp_sp = e.setsp;
            @(negedge clk);
            check({tag, ":MenagePC_clr"}, {29'd0, MenagePC}, 32'd0);
            check({tag, ":SetAP_clr"}, {29'd0, SetAP}, 32'd0);
            check({tag, ":SetSR_clr"}, {24'd0, SetSR}, 32'd0);
            check({tag, ":InDecSP_clr"}, {30'd0, InDecSP}, 32'd0);
            check_bus_free({tag, ":bus_free_idle"});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":SetSP"}, SetSP, 32'd0);
        check({tag, ":InDecSP"}, {30'd0, InDecSP}, 32'd0);
        check({tag, ":MemIO"}, {30'd0, MemIO}, 32'd0);
        check({tag, ":ALUAddr"}, ALUAddr, 32'd0);
        check({tag, ":MenagePC"}, {29'd0, MenagePC}, 32'd0);
        check({tag, ":PCSet"}, PCSet, 32'd0);
        check({tag, ":SetSR"}, {24'd0, SetSR}, 32'd0);
        check({tag, ":SetAP"}, {29'd0, SetAP}, 32'd0);
        check_bus_free({tag, ":bus"});
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [7:0] ops [18];
        logic [7:0] op;
        int wcyc;
        ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd16,
                8'd25, 8'd26, 8'd32, 8'd33, 8'd34, 8'd48, 8'd49, 8'd77};

        // Reset state
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("load", 8'd25, 32'd879199, 32'd0, 24'd0, 8'h00, 32'd0, 32'd500, 4);
        run_op("add", 8'd1, 32'd199, 32'd5, 24'd0, 8'h42, 32'd0, 32'd0, 1);
        run_op("jmp", 8'd48, 32'd0, 32'd0, 24'd250, 8'h00, 32'd0, 32'd0, 1);
        run_op("jz_nt", 8'd49, 32'd0, 32'd0, 24'd999, 8'h00, 32'd0, 32'd0, 1);
        run_op("jz_t", 8'd49, 32'd0, 32'd0, 24'h00ABCD, 8'h01, 32'd0, 32'd0, 1);
        run_op("sub_ovf", 8'd2, 32'h8000_0000, 32'd1, 24'd0, 8'h00, 32'd0, 32'd0, 1);
        run_op("add_wrap", 8'd1, 32'hFFFF_FFFF, 32'd1, 24'd0, 8'hF0, 32'd0, 32'd0, 1);
        run_op("push", 8'd32, 32'd7, 32'd0, 24'd0, 8'h00, 32'd100, 32'd0, 2);
        run_op("pop", 8'd33, 32'd0, 32'd0, 24'd0, 8'h00, 32'd100, 32'h1234_5678, 1);
        run_op("store", 8'd26, 32'h40, 32'hDEAD_BEEF, 24'd0, 8'h35, 32'd0, 32'd0, 3);
        run_op("shl0", 8'd7, 32'h8000_0001, 32'd0, 24'd0, 8'h0A, 32'd0, 32'd0, 1);
        run_op("shl1", 8'd7, 32'h8000_0001, 32'd1, 24'd0, 8'h00, 32'd0, 32'd0, 1);
        run_op("shr31", 8'd8, 32'hC000_0000, 32'd31, 24'd0, 8'h08, 32'd0, 32'd0, 1);
        run_op("cmp_eq", 8'd9, 32'd55, 32'd55, 24'd0, 8'h00, 32'd0, 32'd0, 1);
        run_op("movi", 8'd16, 32'd0, 32'd0, 24'hFFFFFF, 8'h5F, 32'd0, 32'd0, 1);
        run_op("setsp", 8'd34, 32'h0000_2000, 32'd0, 24'd0, 8'h00, 32'd0, 32'd0, 1);
        run_op("nop_op", 8'd77, 32'd1, 32'd2, 24'd3, 8'hA7, 32'd0, 32'd0, 1);

        // Randomized opcodes and operands
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 17)];
            run_op($sformatf("rnd%0d_op%0d", i, op), op, pick_val(), pick_val(),
                   24'($urandom), 8'($urandom), pick_val(), $urandom, $urandom_range(1, 3));
        end

        // Reset while waiting in MEM: everything clears at once, no strobe afterwards
        @(negedge clk);
        ALU_Sel = 8'd25; A = 32'h0000_0777;
        @(posedge clk);
        #1 ALU_Sel = 8'd0;
        wcyc = 0;
        while (MemIO == 2'b00 && wcyc < 10) begin
            @(negedge clk);
            wcyc++;
        end
        check("rst_mem:MemIO_before", {30'd0, MemIO}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mem");
        exp_pc = '0;
        exp_sp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst:MenagePC", {29'd0, MenagePC}, 32'd0);
            check("post_rst:MemIO", {30'd0, MemIO}, 32'd0);
        end
        run_op("post_rst_add", 8'd1, 32'd10, 32'd20, 24'd0, 8'h00, 32'd0, 32'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
